// File: rtl/post_lif_neuron_if.sv
// post_lif_neuron_if: control, synapse inputs and observable outputs of one LIF neuron.
interface post_lif_neuron_if #(parameter int W = 8);
    logic         en;
    logic         spike_a;
    logic         spike_b;
    logic [3:0]   weight_a;
    logic [3:0]   weight_b;
    logic [W-1:0] threshold;
    logic [3:0]   refrac_len;
    logic         count_clr;
    logic         spike_out;
    logic [W-1:0] membrane;
    logic [1:0]   state;
    logic [7:0]   spike_count;
    modport master (
        output en, spike_a, spike_b, weight_a, weight_b, threshold, refrac_len, count_clr,
        input  spike_out, membrane, state, spike_count
    );
    modport slave (
        input  en, spike_a, spike_b, weight_a, weight_b, threshold, refrac_len, count_clr,
        output spike_out, membrane, state, spike_count
    );
endinterface

// File: rtl/post_lif_neuron.sv
// post_lif_neuron: two-synapse leaky integrate-and-fire neuron with refractory period
// and a saturating fire counter.
module post_lif_neuron #(
    parameter int W           = 8,
    parameter int LEAK_PERIOD = 4,
    parameter int LEAK_AMT    = 1
) (
    input logic              clk,
    input logic              rst_n,
    post_lif_neuron_if.slave bus
);
    typedef enum logic [1:0] {INTEGRATE = 2'b00, FIRE = 2'b01, REFRACTORY = 2'b10} state_e;
    localparam logic [W-1:0] MEM_MAX = '1;

    state_e              state_q, state_d;
    logic [W-1:0]        mem_q, mem_d, sat;
    logic [3:0]          leak_q, leak_d, refrac_q, refrac_d;
    logic [7:0]          count_q, count_d;
    logic                spike_q, spike_d;
    logic                leak_due, fire;
    logic signed [W+1:0] sum;

    always_comb begin
        leak_due = leak_q == 4'(LEAK_PERIOD - 1);
        // Two spare bits keep overflow positive and leak underflow negative for clamping.
        sum = signed'({2'b00, mem_q}
                      + (bus.spike_a ? (W+2)'(bus.weight_a) : '0)
                      + (bus.spike_b ? (W+2)'(bus.weight_b) : '0)
                      - (leak_due ? (W+2)'(LEAK_AMT) : '0));
        sat = sum < 0 ? '0 : sum > signed'({2'b00, MEM_MAX}) ? MEM_MAX : sum[W-1:0];
        fire = bus.threshold != '0 && sat >= bus.threshold;
        state_d  = state_q;
        mem_d    = mem_q;
        leak_d   = leak_q;
        refrac_d = refrac_q;
        count_d  = count_q;
        spike_d  = 1'b0;
        case (state_q)
            INTEGRATE: if (bus.en) begin
                state_d  = fire ? FIRE : INTEGRATE;
                mem_d    = fire ? '0 : sat;
                leak_d   = (fire || leak_due) ? 4'd0 : leak_q + 4'd1;
                refrac_d = fire ? bus.refrac_len : refrac_q;
                spike_d  = fire;
                count_d  = (fire && count_q != 8'hff) ? count_q + 8'd1 : count_q;
            end
            FIRE: if (bus.en) state_d = refrac_q == 4'd0 ? INTEGRATE : REFRACTORY;
            REFRACTORY: if (bus.en) begin
                refrac_d = refrac_q - 4'd1;
                state_d  = refrac_q == 4'd1 ? INTEGRATE : REFRACTORY;
            end
            default: state_d = INTEGRATE;
        endcase
        if (bus.en && bus.count_clr) count_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= INTEGRATE;
            mem_q    <= '0;
            leak_q   <= '0;
            refrac_q <= '0;
            count_q  <= '0;
            spike_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mem_q    <= mem_d;
            leak_q   <= leak_d;
            refrac_q <= refrac_d;
            count_q  <= count_d;
            spike_q  <= spike_d;
        end
    end

    assign bus.spike_out   = spike_q;
    assign bus.membrane    = mem_q;
    assign bus.state       = state_q;
    assign bus.spike_count = count_q;
endmodule

// File: tb/tb_post_lif_neuron.sv
// tb_post_lif_neuron: directed vector table plus hand-written multi-cycle sequences.
module tb_post_lif_neuron;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    post_lif_neuron_if #(.W(8)) bus ();
    post_lif_neuron #(.W(8), .LEAK_PERIOD(4), .LEAK_AMT(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic       sa, sb;
        logic [3:0] wa, wb;
        logic [7:0] thr;
        logic [3:0] rl;
        logic       so;
        logic [7:0] mem;
        logic [1:0] st;
        logic [7:0] cnt;
    } vec_t;

    vec_t vec[15];

    function automatic vec_t mk(int sa, int sb, int wa, int wb, int thr, int rl,
                                int so, int mem, int st, int cnt);
        vec_t v;
        v.sa = 1'(sa); v.sb = 1'(sb); v.wa = 4'(wa); v.wb = 4'(wb);
        v.thr = 8'(thr); v.rl = 4'(rl); v.so = 1'(so); v.mem = 8'(mem);
        v.st = 2'(st); v.cnt = 8'(cnt);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sa, input int sb, input int wa, input int wb, input int thr, input int rl);
        bus.spike_a = 1'(sa); bus.spike_b = 1'(sb);
        bus.weight_a = 4'(wa); bus.weight_b = 4'(wb);
        bus.threshold = 8'(thr); bus.refrac_len = 4'(rl);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic chk_all(input string name, input int so, input int mem, input int st, input int cnt);
        chk({name, ".spike_out"}, int'(bus.spike_out), so);
        chk({name, ".membrane"}, int'(bus.membrane), mem);
        chk({name, ".state"}, int'(bus.state), st);
        chk({name, ".spike_count"}, int'(bus.spike_count), cnt);
    endtask

    initial begin
        int pulses;
        bus.en = 1'b1;
        bus.count_clr = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk_all("reset", 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Integration, leak, fire, refractory of 2, exact-threshold fire with zero refractory.
        vec[0]  = mk(1, 0, 5, 0, 20, 2, 0, 5, 0, 0);
        vec[1]  = mk(1, 0, 5, 0, 20, 2, 0, 10, 0, 0);
        vec[2]  = mk(1, 0, 5, 0, 20, 2, 0, 15, 0, 0);
        vec[3]  = mk(1, 0, 5, 0, 20, 2, 0, 19, 0, 0);
        vec[4]  = mk(1, 0, 5, 0, 20, 2, 1, 0, 1, 1);
        vec[5]  = mk(1, 0, 5, 0, 20, 2, 0, 0, 2, 1);
        vec[6]  = mk(1, 0, 5, 0, 20, 2, 0, 0, 2, 1);
        vec[7]  = mk(1, 0, 5, 0, 20, 2, 0, 0, 0, 1);
        vec[8]  = mk(1, 0, 5, 0, 20, 2, 0, 5, 0, 1);
        vec[9]  = mk(0, 0, 5, 0, 20, 2, 0, 5, 0, 1);
        vec[10] = mk(0, 0, 5, 0, 20, 2, 0, 5, 0, 1);
        vec[11] = mk(0, 0, 5, 0, 20, 2, 0, 4, 0, 1);
        vec[12] = mk(1, 0, 5, 0, 9, 0, 1, 0, 1, 2);
        vec[13] = mk(0, 0, 5, 0, 9, 0, 0, 0, 0, 2);
        vec[14] = mk(0, 0, 5, 0, 9, 0, 0, 0, 0, 2);
        for (int i = 0; i < 15; i++) begin
            drive(int'(vec[i].sa), int'(vec[i].sb), int'(vec[i].wa), int'(vec[i].wb),
                  int'(vec[i].thr), int'(vec[i].rl));
            step();
            chk_all($sformatf("vec%0d", i), int'(vec[i].so), int'(vec[i].mem), int'(vec[i].st), int'(vec[i].cnt));
        end

        // Saturation at 255 with firing disabled.
        do_reset();
        drive(1, 1, 15, 15, 0, 0);
        pulses = 0;
        repeat (20) begin
            step();
            pulses += int'(bus.spike_out);
        end
        chk("sat.membrane", int'(bus.membrane), 255);
        chk("sat.pulses", pulses, 0);

        // Leak down from 2 floors at 0.
        do_reset();
        drive(1, 0, 2, 0, 100, 0);
        step();
        chk("leak.start", int'(bus.membrane), 2);
        drive(0, 0, 2, 0, 100, 0);
        repeat (3) step();
        chk("leak.first", int'(bus.membrane), 1);
        repeat (4) step();
        chk("leak.second", int'(bus.membrane), 0);
        repeat (4) step();
        chk("leak.floor", int'(bus.membrane), 0);

        // Periodic firing with refractory 3, enable freeze, count_clr on fire.
        do_reset();
        drive(1, 1, 15, 15, 20, 3);
        step();
        chk_all("per.fire1", 1, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all($sformatf("per.ref%0d", i), 0, 0, 2, 1);
        end
        step();
        chk_all("per.int", 0, 0, 0, 1);
        step();
        chk_all("per.fire2", 1, 0, 1, 2);
        step();
        chk_all("per.ref_a", 0, 0, 2, 2);
        bus.en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_all($sformatf("freeze%0d", i), 0, 0, 2, 2);
        end
        bus.en = 1'b1;
        bus.refrac_len = 4'd7;
        step();
        chk("per.ref_b", int'(bus.state), 2);
        step();
        chk("per.ref_c", int'(bus.state), 2);
        bus.refrac_len = 4'd3;
        step();
        chk("per.int2", int'(bus.state), 0);
        bus.count_clr = 1'b1;
        step();
        chk_all("per.clr_fire", 1, 0, 1, 0);
        bus.count_clr = 1'b0;
        repeat (4) step();
        step();
        chk_all("per.fire4", 1, 0, 1, 1);

        // Fire counter saturates at 255.
        do_reset();
        drive(1, 1, 15, 15, 20, 0);
        repeat (600) step();
        chk("cnt.sat", int'(bus.spike_count), 255);

        // Asynchronous reset in the middle of FIRE.
        do_reset();
        drive(1, 1, 15, 15, 20, 3);
        step();
        chk_all("arst.fire", 1, 0, 1, 1);
        #2 rst_n = 1'b0;
        #1;
        chk_all("arst.now", 0, 0, 0, 0);
        #1 rst_n = 1'b1;
        step();
        chk_all("arst.resume", 1, 0, 1, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/post_lif_neuron.md
POST_LIF_NEURON -- requirements
Module: post_lif_neuron

Interface
REQ-001 SHALL provide parameter W, default 8, membrane and threshold width in bits.
REQ-002 SHALL provide parameter LEAK_PERIOD, default 4, number of integrating cycles between leak events (valid 1..15).
REQ-003 SHALL provide parameter LEAK_AMT, default 1, amount subtracted from the membrane per leak event.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  advance enable; 0 freezes all state.
REQ-007 spike_a  input  1  spike from upstream synapse A, sampled each enabled cycle.
REQ-008 spike_b  input  1  spike from upstream synapse B, sampled each enabled cycle.
REQ-009 weight_a  input  4  unsigned weight added when spike_a=1.
REQ-010 weight_b  input  4  unsigned weight added when spike_b=1.
REQ-011 threshold  input  W  firing threshold; 0 disables firing.
REQ-012 refrac_len  input  4  refractory length in cycles; sampled on entry to FIRE.
REQ-013 count_clr  input  1  synchronous clear of spike_count.
REQ-014 spike_out  output  1  registered one-cycle fire pulse.
REQ-015 membrane  output  W  current registered membrane potential.
REQ-016 state  output  2  00 INTEGRATE, 01 FIRE, 10 REFRACTORY.
REQ-017 spike_count  output  8  saturating count of fires.

Function
REQ-018 States SHALL be INTEGRATE, FIRE, REFRACTORY; encoding 11 is illegal and SHALL recover to INTEGRATE on the next edge.
REQ-019 When en=0, state, membrane, leak counter, refractory counter and spike_count SHALL hold, and spike_out SHALL be 0.
REQ-020 In INTEGRATE with en=1: sum = membrane + (spike_a?weight_a:0) + (spike_b?weight_b:0) - (leak_due?LEAK_AMT:0), computed at W+2 bits signed.
REQ-021 leak_due SHALL be 1 when the internal leak counter equals LEAK_PERIOD-1; the counter increments each enabled INTEGRATE cycle, wrapping to 0 after LEAK_PERIOD-1.
REQ-022 sum SHALL saturate to 2^W-1 on overflow and floor at 0 on underflow; no wrap-around.
REQ-023 If threshold != 0 and saturated sum >= threshold, the next state SHALL be FIRE, membrane SHALL become 0, leak counter SHALL reset to 0; otherwise membrane SHALL become the saturated sum.
REQ-024 spike_out SHALL be 1 exactly during the FIRE cycle, i.e. one cycle latency after the threshold-crossing edge.
REQ-025 FIRE SHALL last one enabled cycle, then go to REFRACTORY loaded with refrac_len, or directly to INTEGRATE if refrac_len=0.
REQ-026 REFRACTORY SHALL last exactly refrac_len enabled cycles; spike inputs ignored, membrane held at 0, leak counter held.
REQ-027 Under continuous supra-threshold input, fire period SHALL be refrac_len+2 cycles.
REQ-028 spike_count SHALL increment by 1 on each entry to FIRE, saturating at 255.
REQ-029 count_clr SHALL take priority: simultaneous clear and fire entry yields spike_count=0.
REQ-030 Changes to weight_a, weight_b, threshold SHALL take effect on the next enabled edge; refrac_len changes during REFRACTORY SHALL not affect the running count.

Reset
REQ-031 rst_n=0 SHALL immediately, independent of clk, force state=INTEGRATE, membrane=0, spike_out=0, spike_count=0, leak and refractory counters=0.
REQ-032 Reset asserted mid-FIRE or mid-REFRACTORY SHALL abort the sequence; after release the block resumes in INTEGRATE on the first enabled edge.

Verification
REQ-033 weight_a=5, threshold=20, spike_a=1 held, spike_b=0 -> membrane 5,10,15,19, then spike_out=1 on cycle after 5th edge, membrane=0.
REQ-034 weight_a=weight_b=15, threshold=0, both spikes held 20 cycles -> membrane saturates at 255 and holds, spike_out never 1.
REQ-035 membrane=2, no spikes, threshold=100 -> membrane drops to 1 at first leak, 0 at second, stays 0, no underflow.
REQ-036 weights 15+15, threshold=20, refrac_len=3, spikes held -> spike_out pulses every 5 cycles, state sequence FIRE, REFRACTORY x3, INTEGRATE; spike_count increments per pulse.
REQ-037 en=0 for 10 cycles mid-REFRACTORY -> all outputs frozen, spike_out=0, sequence resumes on en=1; count_clr coincident with fire -> spike_count=0.
REQ-038 rst_n pulsed low between clock edges during FIRE -> spike_out, membrane, spike_count immediately 0, state=INTEGRATE.
